fp_normalize_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational leading-one normaliser used in the FP subtract datapath.
- Accepts an unnormalised mantissa/exponent pair from the add/sub stage.
- Returns an IEEE-754 normalised result with exponent-underflow clamping to subnormal, zero detection and a pass-through tag.
- Two-stage pipeline with valid/ready handshake; sits between the mantissa subtractor and the rounding stage.

---
 rtl/fp_normalize_pipe.sv | 123 ++++++++++++
 tb/tb_fp_normalize_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize_pipe.sv
// fp_normalize_pipe: two-stage leading-one normaliser with subnormal clamp.
// Ports: clk/rst_n, in_* valid/ready operand, out_* valid/ready result.
module fp_normalize_pipe #(
  parameter int MAN_W = 24,
  parameter int EXP_W = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W-1:0] in_man,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W-1:0] out_man,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_zero,
  output logic             out_denorm,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LZ_W = $clog2(MAN_W + 1);

  typedef struct packed {
    logic [MAN_W-1:0] man;
    logic [EXP_W-1:0] exp;
    logic [TAG_W-1:0] tag;
    logic [LZ_W-1:0]  lz;
    logic             zero;
  } s1_t;

  s1_t             s1_d;
  s1_t             s1_q;
  logic            s1_valid;
  logic            s2_ready;
  logic [LZ_W-1:0] lz;

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;

  // Highest set bit wins as the scan climbs.
  always_comb begin
    lz = LZ_W'(MAN_W);
    for (int i = 0; i < MAN_W; i++) begin
      if (in_man[i]) lz = LZ_W'(MAN_W - 1 - i);
    end
  end

  always_comb begin
    s1_d.man  = in_man;
    s1_d.exp  = in_exp;
    s1_d.tag  = in_tag;
    s1_d.lz   = lz;
    s1_d.zero = (in_man == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  logic [EXP_W-1:0] lz_ext;
  logic [LZ_W-1:0]  sh;
  logic [MAN_W-1:0] n_man;
  logic [EXP_W-1:0] n_exp;
  logic             n_zero;
  logic             n_den;
  logic             is_sub;
  logic             is_norm;

  assign lz_ext  = EXP_W'(s1_q.lz);
  assign is_sub  = !s1_q.zero && (s1_q.exp == '0);
  assign is_norm = !s1_q.zero && (s1_q.exp > lz_ext);

  // Underflow shifts only as far as exponent 1 allows, then clamps to 0.
  always_comb begin
    sh     = '0;
    n_exp  = '0;
    n_zero = 1'b0;
    n_den  = 1'b0;
    unique case (1'b1)
      s1_q.zero: n_zero = 1'b1;
      is_sub:    n_den  = 1'b1;
      is_norm: begin
        sh    = s1_q.lz;
        n_exp = s1_q.exp - lz_ext;
      end
      default: begin
        sh    = LZ_W'(s1_q.exp - 1'b1);
        n_den = 1'b1;
      end
    endcase
    n_man = s1_q.man << sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_man    <= '0;
      out_exp    <= '0;
      out_zero   <= 1'b0;
      out_denorm <= 1'b0;
      out_tag    <= '0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_man    <= n_man;
        out_exp    <= n_exp;
        out_zero   <= n_zero;
        out_denorm <= n_den;
        out_tag    <= s1_q.tag;
      end
    end
  end

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// tb_fp_normalize_pipe: directed and random checks of fp_normalize_pipe.
// Scoreboard of expected results against a loop-based reference model.
module tb_fp_normalize_pipe;

  typedef struct packed {
    logic [23:0] man;
    logic [7:0]  exp;
    logic        zero;
    logic        den;
    logic [3:0]  tag;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_man;
  logic [7:0]  in_exp;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_man;
  logic [7:0]  out_exp;
  logic        out_zero;
  logic        out_denorm;
  logic [3:0]  out_tag;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   out_cnt = 0;
  int   stall_cnt = 0;
  bit   bp_rand = 0;
  res_t drv_exp;
  res_t sb[$];

  fp_normalize_pipe #(.MAN_W(24), .EXP_W(8), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_man(in_man), .in_exp(in_exp), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_man(out_man), .out_exp(out_exp),
    .out_zero(out_zero), .out_denorm(out_denorm),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic res_t mk(logic [23:0] m, logic [7:0] e,
                              logic z, logic d, logic [3:0] t);
    res_t r;
    r.man = m; r.exp = e; r.zero = z; r.den = d; r.tag = t;
    return r;
  endfunction

  // Reference: shift left one place at a time while the exponent
  // can still drop and the hidden bit is clear.
  function automatic res_t model(logic [23:0] m, logic [7:0] e,
                                 logic [3:0] t);
    int ee;
    if (m == 0) return mk(24'h0, 8'd0, 1'b1, 1'b0, t);
    if (e == 0) return mk(m, 8'd0, 1'b0, 1'b1, t);
    ee = e;
    while (!m[23] && ee > 1) begin
      m = m << 1;
      ee--;
    end
    if (m[23]) return mk(m, 8'(ee), 1'b0, 1'b0, t);
    return mk(m, 8'd0, 1'b0, 1'b1, t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else if (bp_rand) begin
      out_ready = 1'($urandom_range(0, 1));
    end else begin
      out_ready = 1'b1;
    end
  endtask

  task automatic send(logic [23:0] m, logic [7:0] e, logic [3:0] t,
                      res_t r);
    bit acc;
    acc = 0;
    in_valid = 1'b1;
    in_man = m;
    in_exp = e;
    in_tag = t;
    drv_exp = r;
    for (int n = 0; n < 50; n++) begin
      acc = in_ready;
      tick();
      if (acc) break;
    end
    chk("accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bp_rand = 0;
    stall_cnt = 0;
    for (int n = 0; n < 100; n++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: result order, stall stability, in_ready rule.
  initial begin
    bit   hold_v;
    res_t hold_r;
    res_t obs;
    res_t e;
    bit   exp_rdy;
    hold_v = 0;
    hold_r = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        hold_v = 0;
      end else begin
        obs = mk(out_man, out_exp, out_zero, out_denorm, out_tag);
        if (hold_v) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_data", 64'(obs), 64'(hold_r));
        end
        exp_rdy = !(out_valid && !out_ready && sb.size() == 2);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("spurious_out", 64'(out_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("result", 64'(obs), 64'(e));
          end
          out_cnt++;
        end
        hold_v = out_valid && !out_ready;
        hold_r = obs;
        if (in_valid && in_ready) sb.push_back(drv_exp);
      end
    end
  end

  initial begin
    logic [23:0] m;
    logic [7:0]  e;
    logic [3:0]  t;
    int          c0;
    int          cs;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_man = '0;
    in_exp = '0;
    in_tag = '0;
    out_ready = 1'b1;
    drv_exp = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",
        64'(mk(out_man, out_exp, out_zero, out_denorm, out_tag)), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    send(24'h000001, 8'd100, 4'd1, mk(24'h800000, 8'd77, 0, 0, 4'd1));
    send(24'h000001, 8'd24,  4'd2, mk(24'h800000, 8'd1,  0, 0, 4'd2));
    send(24'h000001, 8'd23,  4'd3, mk(24'h400000, 8'd0,  0, 1, 4'd3));
    send(24'h000100, 8'd10,  4'd4, mk(24'h020000, 8'd0,  0, 1, 4'd4));
    send(24'h000000, 8'd50,  4'd5, mk(24'h000000, 8'd0,  1, 0, 4'd5));
    send(24'h400000, 8'd0,   4'd6, mk(24'h400000, 8'd0,  0, 1, 4'd6));
    send(24'h800000, 8'd5,   4'd7, mk(24'h800000, 8'd5,  0, 0, 4'd7));
    send(24'h800000, 8'd255, 4'd8, mk(24'h800000, 8'd255, 0, 0, 4'd8));
    drain();

    bp_rand = 1;
    stall_cnt = 3;
    for (int i = 0; i < 6; i++) begin
      m = 24'($urandom) >> $urandom_range(0, 24);
      e = 8'($urandom_range(0, 40));
      send(m, e, 4'(i), model(m, e, 4'(i)));
    end
    drain();

    out_ready = 1'b1;
    c0 = out_cnt;
    cs = cyc;
    for (int i = 0; i < 8; i++) begin
      m = 24'($urandom) >> $urandom_range(0, 24);
      e = 8'($urandom_range(1, 60));
      send(m, e, 4'(i + 8), model(m, e, 4'(i + 8)));
    end
    chk("tp_cycles", 64'(cyc - cs), 64'd8);
    tick();
    tick();
    chk("tp_outputs", 64'(out_cnt - c0), 64'd8);
    drain();

    bp_rand = 1;
    for (int i = 0; i < 40; i++) begin
      if (i == 10 || i == 25) stall_cnt = 3;
      m = 24'($urandom) >> $urandom_range(0, 24);
      if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(0, 255));
      else e = 8'($urandom_range(0, 30));
      t = 4'($urandom);
      send(m, e, t, model(m, e, t));
    end
    drain();

    out_ready = 1'b1;
    send(24'h000010, 8'd40, 4'hA, mk(24'h800000, 8'd21, 0, 0, 4'hA));
    send(24'h000020, 8'd40, 4'hB, mk(24'h800000, 8'd22, 0, 0, 4'hB));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_idle", 64'(out_valid), 64'd0);
    end
    send(24'h000003, 8'd30, 4'hC, mk(24'hC00000, 8'd8, 0, 0, 4'hC));
    chk("lat_c1", 64'(out_valid), 64'd0);
    tick();
    chk("lat_c2", 64'(out_valid), 64'd1);
    chk("lat_tag", 64'(out_tag), 64'hC);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
